pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined main controller for the RV32I core: decodes the ID-stage opcode, then carries the control word through the ID/EX, EX/MEM and MEM/WB registers.
//  Handles hazard stalls, branch flushes and a halt that drains in-flight instructions before stopping.
//  Sits beside the datapath pipeline registers. Each stage reads its own control fields from this block.
// PARAMETERS
//  DRAIN_CYCLES  3            cycles from HALT leaving ID until halted=1 (EX,MEM,WB retire)
//  EXT_ISA       1            1: also decode JAL/JALR/LUI/AUIPC; 0: those opcodes are illegal
//  HALT_OPCODE   7'b1111111   opcode that requests halt
// PORTS
//  clk            in   1  core clock, all state on rising edge
//  reset          in   1  asynchronous, active-high; clears all state
//  id_valid       in   1  ID holds a real instruction
//  opcode         in   7  instruction[6:0] of ID instruction
//  stall          in   1  hazard unit: ID holds, bubble into EX
//  flush          in   1  branch/jump taken in EX: kill ID instruction
//  ex_alu_src     out  1  0: rs2, 1: immediate
//  ex_alu_op      out  2  00 add(LW/SW/LUI/AUIPC/JALR), 01 branch, 10 R, 11 I
//  ex_branch      out  1  conditional branch in EX
//  ex_jump        out  2  00 none, 01 JAL, 10 JALR
//  mem_read       out  1  load in MEM
//  mem_write      out  1  store in MEM
//  wb_reg_write   out  1  write rd in WB
//  wb_sel         out  2  00 ALU, 01 MEM, 10 PC+4, 11 imm (LUI)
//  halt_req       out  1  freeze PC/IF-ID (high in DRAIN and HALTED)
//  halted         out  1  pipeline empty, core stopped
//  illegal        out  1  one-cycle pulse: valid ID opcode undecodable
//  illegal_seen   out  1  sticky copy of illegal until reset
// BEHAVIOUR
//  - Reset: every output 0, all stage valids 0, state RUN, drain counter 0. Reset mid-drain or while halted returns to RUN.
//  - Decode is combinational in ID. The ID/EX register loads at each edge:
//    - bubble (all 0) if flush, stall, !id_valid, illegal opcode, HALT opcode, or state!=RUN;
//    - otherwise the decoded word.
//  - EX->MEM and MEM->WB advance unconditionally every cycle; stall never freezes them.
//  - Latency: ex_* valid 1 cycle after ID, mem_* 2 cycles, wb_* 3 cycles.
//  - Field rules: R: reg_write. I: alu_src, reg_write. LW: alu_src, mem_read, reg_write, wb_sel=01. SW: alu_src, mem_write. BR: branch, alu_op=01.
//  - EXT_ISA field rules:
//    - JAL: jump=01, reg_write, wb_sel=10.
//    - JALR: jump=10, alu_src, reg_write, wb_sel=10.
//    - LUI: alu_src, reg_write, wb_sel=11.
//    - AUIPC: alu_src, reg_write, wb_sel=00.
//  - Priority: flush > stall > decode. Flush+stall in same cycle: bubble, no stall effect.
//  - illegal: asserted combinationally when id_valid & !flush & !stall & opcode undecodable; illegal_seen set at the next edge.
//  - Halt FSM, states RUN / DRAIN / HALTED:
//    - RUN->DRAIN when HALT in ID with id_valid & !stall & !flush; counter loads DRAIN_CYCLES-1.
//    - DRAIN: halt_req=1; decrement each cycle. A flush in DRAIN cancels halt (HALT was on wrong path) -> RUN, counter cleared, halt_req drops next cycle.
//    - DRAIN->HALTED when counter==0 and no flush. HALTED: halt_req=1, halted=1; holds until reset.
//    - HALT while stalled: stays in ID; transition takes place when stall drops.
//  - Counter width $clog2(DRAIN_CYCLES+1); DRAIN_CYCLES>=1 is an elaboration check.
// STRUCTURE
//  - ctrl_pkg: opcode localparams, alu_op_e, jump_e, wb_sel_e, halt_state_e, packed ctrl_word_t {alu_src, alu_op, branch, jump, mem_read, mem_write, reg_write, wb_sel}, CTRL_BUBBLE.
//  - Sub-module ctrl_decode: combinational opcode -> ctrl_word_t + illegal, parameter EXT_ISA.
//  - Top: three ctrl_word_t stage registers, halt FSM, drain counter.
// TESTING
//  1. id_valid=1, opcodes LW,SW,R,I,BR in successive cycles:
//     - ex_* matches the field table 1 cycle after each;
//     - LW gives mem_read=1 at +2 and wb_sel=01, wb_reg_write=1 at +3.
//  2. stall=1 with LW in ID for 2 cycles: EX sees 2 bubbles, then the LW word; MEM/WB keep advancing.
//  3. flush=1 and stall=1 with SW in ID: EX bubble; mem_write=0 at +2; illegal=0.
//  4. HALT in ID at cycle t with DRAIN_CYCLES=3:
//     - halt_req=1 from t+1;
//     - halted=1 at t+3;
//     - holds 10 cycles; reset clears both.
//  5. HALT in ID, flush at t+1: state back to RUN, halt_req=0 at t+2, halted never set.
//  6. EXT_ISA=0, opcode JAL (7'b1101111): illegal pulse 1 cycle, illegal_seen stays 1, EX bubble. EXT_ISA=1: jump=01, wb_sel=10.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control-field encodings and stage-register layouts
// for the pipelined main controller.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_REG    = 2'b10,
    ALU_IMM    = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'b00,
    JUMP_JAL  = 2'b01,
    JUMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } halt_state_e;

  typedef struct packed {
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    jump_e   jump;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
  } ctrl_word_t;

  // Later stages only carry the fields still consumed downstream.
  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
  } mem_ctrl_t;

  typedef struct packed {
    logic    reg_write;
    wb_sel_e wb_sel;
  } wb_ctrl_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;
  localparam mem_ctrl_t  MEM_BUBBLE  = '0;
  localparam wb_ctrl_t   WB_BUBBLE   = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage opcode decoder: control word, halt detect and
// illegal-opcode flag. The halt opcode is recognised but never illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int         EXT_ISA     = 1,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
  input  logic [6:0] opcode,
  output ctrl_word_t word,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    word    = CTRL_BUBBLE;
    is_halt = (opcode == HALT_OPCODE);
    illegal = 1'b0;
    case (opcode)
      OP_REG: begin
        word.alu_op    = ALU_REG;
        word.reg_write = 1'b1;
      end
      OP_IMM: begin
        word.alu_src   = 1'b1;
        word.alu_op    = ALU_IMM;
        word.reg_write = 1'b1;
      end
      OP_LOAD: begin
        word.alu_src   = 1'b1;
        word.mem_read  = 1'b1;
        word.reg_write = 1'b1;
        word.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        word.alu_src   = 1'b1;
        word.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        word.branch = 1'b1;
        word.alu_op = ALU_BRANCH;
      end
      OP_JAL: begin
        if (EXT_ISA != 0) begin
          word.jump      = JUMP_JAL;
          word.reg_write = 1'b1;
          word.wb_sel    = WB_PC4;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JALR: begin
        if (EXT_ISA != 0) begin
          word.jump      = JUMP_JALR;
          word.alu_src   = 1'b1;
          word.reg_write = 1'b1;
          word.wb_sel    = WB_PC4;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT_ISA != 0) begin
          word.alu_src   = 1'b1;
          word.reg_write = 1'b1;
          word.wb_sel    = WB_IMM;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (EXT_ISA != 0) begin
          word.alu_src   = 1'b1;
          word.reg_write = 1'b1;
          word.wb_sel    = WB_ALU;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = !is_halt;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main controller: ID decode, ID/EX, EX/MEM and MEM/WB control
// registers, and the RUN/DRAIN/HALTED halt sequencer.
//
// Handshake: there is no valid/ready pair here. id_valid qualifies the ID
// opcode; stall and flush are unconditional commands that win over decode
// (flush > stall > decode), and EX/MEM/WB advance every cycle regardless.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int         DRAIN_CYCLES = 3,
  parameter int         EXT_ISA      = 1,
  parameter logic [6:0] HALT_OPCODE  = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic       stall,
  input  logic       flush,
  output logic       ex_alu_src,
  output logic [1:0] ex_alu_op,
  output logic       ex_branch,
  output logic [1:0] ex_jump,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_reg_write,
  output logic [1:0] wb_sel,
  output logic       halt_req,
  output logic       halted,
  output logic       illegal,
  output logic       illegal_seen,
  output logic [1:0] fsm_state
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("pipe_ctrl_unit: DRAIN_CYCLES must be at least 1");
    end
  endgenerate

  ctrl_word_t  dec_word;
  logic        dec_halt;
  logic        dec_illegal;
  logic        issue_ok;
  logic        halt_take;
  ctrl_word_t  id_word;
  ctrl_word_t  id_ex;
  mem_ctrl_t   ex_mem;
  wb_ctrl_t    mem_wb;
  halt_state_e state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;

  ctrl_decode #(
    .EXT_ISA     (EXT_ISA),
    .HALT_OPCODE (HALT_OPCODE)
  ) u_decode (
    .opcode  (opcode),
    .word    (dec_word),
    .is_halt (dec_halt),
    .illegal (dec_illegal)
  );

  assign issue_ok  = id_valid & ~flush & ~stall;
  assign halt_take = issue_ok & dec_halt & (state == ST_RUN);
  assign illegal   = issue_ok & dec_illegal & ~reset;

  always_comb begin
    id_word = CTRL_BUBBLE;
    if (issue_ok && (state == ST_RUN) && !dec_illegal && !dec_halt) begin
      id_word = dec_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex        <= CTRL_BUBBLE;
      ex_mem       <= MEM_BUBBLE;
      mem_wb       <= WB_BUBBLE;
      illegal_seen <= 1'b0;
    end else begin
      id_ex            <= id_word;
      ex_mem.mem_read  <= id_ex.mem_read;
      ex_mem.mem_write <= id_ex.mem_write;
      ex_mem.reg_write <= id_ex.reg_write;
      ex_mem.wb_sel    <= id_ex.wb_sel;
      mem_wb.reg_write <= ex_mem.reg_write;
      mem_wb.wb_sel    <= ex_mem.wb_sel;
      if (illegal) begin
        illegal_seen <= 1'b1;
      end
    end
  end

  assign ex_alu_src   = id_ex.alu_src;
  assign ex_alu_op    = id_ex.alu_op;
  assign ex_branch    = id_ex.branch;
  assign ex_jump      = id_ex.jump;
  assign mem_read     = ex_mem.mem_read;
  assign mem_write    = ex_mem.mem_write;
  assign wb_reg_write = mem_wb.reg_write;
  assign wb_sel       = mem_wb.wb_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // cnt holds the DRAIN cycles still to go, including the current one, so
  // HALTED is entered exactly DRAIN_CYCLES cycles after HALT leaves ID.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_RUN: begin
        if (halt_take) begin
          if (CNT_LOAD == '0) begin
            next_state = ST_HALTED;
          end else begin
            next_state = ST_DRAIN;
            next_cnt   = CNT_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (flush) begin
          next_state = ST_RUN;
          next_cnt   = '0;
        end else if (cnt <= CNT_ONE) begin
          next_state = ST_HALTED;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - CNT_ONE;
        end
      end
      ST_HALTED: begin
        next_state = ST_HALTED;
      end
      default: begin
        next_state = ST_RUN;
        next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    halt_req = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_DRAIN: halt_req = 1'b1;
      ST_HALTED: begin
        halt_req = 1'b1;
        halted   = 1'b1;
      end
      default: ;
    endcase
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance with the extended ISA and one
// without, both driven identically and checked against a cycle-indexed model.
module tb_pipe_ctrl_unit;

  localparam int DRAIN = 3;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_HALT  = 7'b1111111;
  localparam logic [6:0] OP_BAD   = 7'b0001111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic started = 1'b0;

  always #5 clk = ~clk;

  logic x_ex_alu_src, x_ex_branch, x_mem_read, x_mem_write, x_wb_reg_write;
  logic [1:0] x_ex_alu_op, x_ex_jump, x_wb_sel, x_fsm_state;
  logic x_halt_req, x_halted, x_illegal, x_illegal_seen;
  logic n_ex_alu_src, n_ex_branch, n_mem_read, n_mem_write, n_wb_reg_write;
  logic [1:0] n_ex_alu_op, n_ex_jump, n_wb_sel, n_fsm_state;
  logic n_halt_req, n_halted, n_illegal, n_illegal_seen;

  pipe_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .EXT_ISA(1), .HALT_OPCODE(OP_HALT)) dut_ext (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .stall(stall), .flush(flush),
    .ex_alu_src(x_ex_alu_src), .ex_alu_op(x_ex_alu_op), .ex_branch(x_ex_branch), .ex_jump(x_ex_jump),
    .mem_read(x_mem_read), .mem_write(x_mem_write), .wb_reg_write(x_wb_reg_write), .wb_sel(x_wb_sel),
    .halt_req(x_halt_req), .halted(x_halted), .illegal(x_illegal), .illegal_seen(x_illegal_seen),
    .fsm_state(x_fsm_state)
  );

  pipe_ctrl_unit #(.DRAIN_CYCLES(DRAIN), .EXT_ISA(0), .HALT_OPCODE(OP_HALT)) dut_base (
    .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .stall(stall), .flush(flush),
    .ex_alu_src(n_ex_alu_src), .ex_alu_op(n_ex_alu_op), .ex_branch(n_ex_branch), .ex_jump(n_ex_jump),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .wb_reg_write(n_wb_reg_write), .wb_sel(n_wb_sel),
    .halt_req(n_halt_req), .halted(n_halted), .illegal(n_illegal), .illegal_seen(n_illegal_seen),
    .fsm_state(n_fsm_state)
  );

  // ---------------- reference model ----------------
  // Word layout: [10] alu_src [9:8] alu_op [7] branch [6:5] jump
  //              [4] mem_read [3] mem_write [2] reg_write [1:0] wb_sel
  function automatic logic [10:0] exp_word(input logic [6:0] op, input logic ext);
    case (op)
      OP_LW:    return 11'b1_00_0_00_1_0_1_01;
      OP_SW:    return 11'b1_00_0_00_0_1_0_00;
      OP_R:     return 11'b0_10_0_00_0_0_1_00;
      OP_I:     return 11'b1_11_0_00_0_0_1_00;
      OP_BR:    return 11'b0_01_1_00_0_0_0_00;
      OP_JAL:   return ext ? 11'b0_00_0_01_0_0_1_10 : 11'd0;
      OP_JALR:  return ext ? 11'b1_00_0_10_0_0_1_10 : 11'd0;
      OP_LUI:   return ext ? 11'b1_00_0_00_0_0_1_11 : 11'd0;
      OP_AUIPC: return ext ? 11'b1_00_0_00_0_0_1_00 : 11'd0;
      default:  return 11'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] op, input logic ext);
    if (op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BR) return 1'b1;
    if (ext && (op == OP_JAL || op == OP_JALR || op == OP_LUI || op == OP_AUIPC)) return 1'b1;
    return 1'b0;
  endfunction

  // exp_q[0] is the word in EX, [1] in MEM, [2] in WB.
  logic [10:0] exp_q [$] = '{11'd0, 11'd0, 11'd0};
  logic [10:0] exp_q_n [$] = '{11'd0, 11'd0, 11'd0};
  int cyc = 0;
  int halt_at = -1;
  logic seen_x = 1'b0;
  logic seen_n = 1'b0;
  logic m_ok, m_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q = '{11'd0, 11'd0, 11'd0};
      exp_q_n = '{11'd0, 11'd0, 11'd0};
      cyc = 0;
      halt_at = -1;
      seen_x = 1'b0;
      seen_n = 1'b0;
    end else begin
      m_ok = id_valid && !flush && !stall;
      m_run = (halt_at < 0);
      exp_q.push_front((m_ok && m_run && is_legal(opcode, 1'b1)) ? exp_word(opcode, 1'b1) : 11'd0);
      void'(exp_q.pop_back());
      exp_q_n.push_front((m_ok && m_run && is_legal(opcode, 1'b0)) ? exp_word(opcode, 1'b0) : 11'd0);
      void'(exp_q_n.pop_back());
      if (m_ok && !is_legal(opcode, 1'b1) && opcode != OP_HALT) seen_x = 1'b1;
      if (m_ok && !is_legal(opcode, 1'b0) && opcode != OP_HALT) seen_n = 1'b1;
      if (halt_at >= 0 && flush && cyc > halt_at && cyc < halt_at + DRAIN) halt_at = -1;
      else if (m_run && m_ok && opcode == OP_HALT) halt_at = cyc;
      cyc++;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  logic exp_illegal_x, exp_illegal_n, exp_hr, exp_hd;

  always @(negedge clk) begin
    if (started && !reset) begin
      exp_illegal_x = id_valid && !flush && !stall && !is_legal(opcode, 1'b1) && opcode != OP_HALT;
      exp_illegal_n = id_valid && !flush && !stall && !is_legal(opcode, 1'b0) && opcode != OP_HALT;
      exp_hr = (halt_at >= 0) && (cyc > halt_at);
      exp_hd = (halt_at >= 0) && (cyc >= halt_at + DRAIN);
      chk("x_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, exp_q[0][10:5]);
      chk("x_mem", {x_mem_read, x_mem_write}, exp_q[1][4:3]);
      chk("x_wb", {x_wb_reg_write, x_wb_sel}, exp_q[2][2:0]);
      chk("n_ex", {n_ex_alu_src, n_ex_alu_op, n_ex_branch, n_ex_jump}, exp_q_n[0][10:5]);
      chk("n_mem", {n_mem_read, n_mem_write}, exp_q_n[1][4:3]);
      chk("n_wb", {n_wb_reg_write, n_wb_sel}, exp_q_n[2][2:0]);
      chk("x_illegal", x_illegal, exp_illegal_x);
      chk("n_illegal", n_illegal, exp_illegal_n);
      chk("x_illegal_seen", x_illegal_seen, seen_x);
      chk("n_illegal_seen", n_illegal_seen, seen_n);
      chk("x_halt", {x_halt_req, x_halted}, {exp_hr, exp_hd});
      chk("n_halt", {n_halt_req, n_halted}, {exp_hr, exp_hd});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [6:0] op, input logic s, input logic f);
    @(posedge clk);
    #2;
    id_valid = v;
    opcode = op;
    stall = s;
    flush = f;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    id_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_halt", {x_halt_req, x_halted, n_halt_req, n_halted}, 4'b0000);
    chk("rst_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'd0);
    chk("rst_mem_wb", {x_mem_read, x_mem_write, x_wb_reg_write, x_wb_sel}, 5'd0);
    chk("rst_seen", {x_illegal_seen, n_illegal_seen, x_illegal, n_illegal}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic       s;
    logic       f;
  } vec_t;

  vec_t vecs [0:15] = '{
    '{1'b1, OP_JALR, 1'b0, 1'b0}, '{1'b1, OP_LUI, 1'b0, 1'b0},
    '{1'b1, OP_AUIPC, 1'b0, 1'b0}, '{1'b1, OP_BAD, 1'b0, 1'b0},
    '{1'b1, OP_R, 1'b0, 1'b1}, '{1'b1, OP_I, 1'b1, 1'b0},
    '{1'b0, OP_LW, 1'b0, 1'b0}, '{1'b1, OP_BAD, 1'b1, 1'b0},
    '{1'b1, OP_HALT, 1'b1, 1'b1}, '{1'b1, OP_HALT, 1'b1, 1'b0},
    '{1'b1, OP_HALT, 1'b1, 1'b0}, '{1'b1, OP_HALT, 1'b0, 1'b0},
    '{1'b1, OP_LW, 1'b0, 1'b0}, '{1'b0, 7'd0, 1'b0, 1'b0},
    '{1'b0, 7'd0, 1'b0, 1'b0}, '{1'b0, 7'd0, 1'b0, 1'b0}
  };

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);
    chk("reset_state", {x_halt_req, x_halted, x_illegal_seen, x_mem_read, x_wb_reg_write}, 5'd0);

    // LW, SW, R, I, BR back to back
    step(1'b1, OP_LW, 1'b0, 1'b0);
    step(1'b1, OP_SW, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_lw_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'b1_00_0_00);
    step(1'b1, OP_R, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_lw_mem_read", x_mem_read, 1'b1);
    step(1'b1, OP_I, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_lw_wb", {x_wb_reg_write, x_wb_sel}, 3'b101);
    chk("lit_r_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'b0_10_0_00);
    chk("lit_sw_mem_write", x_mem_write, 1'b1);
    step(1'b1, OP_BR, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_i_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'b1_11_0_00);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_br_ex", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'b0_01_1_00);

    // LW held by a two-cycle stall
    step(1'b1, OP_LW, 1'b1, 1'b0);
    step(1'b1, OP_LW, 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_stall_bubble", {x_ex_alu_src, x_ex_alu_op, x_mem_read}, 4'd0);
    step(1'b1, OP_LW, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_stall_release", {x_ex_alu_src, x_ex_alu_op, x_ex_branch, x_ex_jump}, 6'b1_00_0_00);

    // flush together with stall kills SW
    step(1'b1, OP_SW, 1'b1, 1'b1);
    @(negedge clk);
    chk("lit_flush_illegal", x_illegal, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_flush_mem_write", x_mem_write, 1'b0);

    // halt drains and holds until reset
    step(1'b1, OP_HALT, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_halt_t1", {x_halt_req, x_halted}, 2'b10);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    step(1'b1, OP_LW, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_halt_t3", {x_halt_req, x_halted}, 2'b11);
    repeat (10) step(1'b1, OP_R, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_halt_hold", {x_halt_req, x_halted, x_ex_alu_op}, 4'b1100);
    apply_reset();

    // halt cancelled by a flush in the drain window
    step(1'b1, OP_HALT, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b1);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_cancel_t2", x_halt_req, 1'b0);
    repeat (5) step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_cancel_never", x_halted, 1'b0);

    // JAL: illegal on the base instance, decoded on the extended one
    step(1'b1, OP_JAL, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_jal_illegal", {n_illegal, x_illegal}, 2'b10);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_jal_pulse", {n_illegal, n_illegal_seen}, 2'b01);
    chk("lit_jal_base_ex", {n_ex_alu_src, n_ex_alu_op, n_ex_branch, n_ex_jump}, 6'd0);
    chk("lit_jal_ext_ex", x_ex_jump, 2'b01);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_jal_wb", {x_wb_reg_write, x_wb_sel, n_illegal_seen}, 4'b1101);

    // remaining opcodes, stalled/flushed corners and a stalled HALT
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].v, vecs[i].op, vecs[i].s, vecs[i].f);
    end
    repeat (4) step(1'b0, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_stalled_halt", {x_halt_req, x_halted}, 2'b11);
    apply_reset();
    repeat (3) step(1'b1, OP_SW, 1'b0, 1'b0);
    step(1'b0, 7'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
